// File: rtl/cache_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cache_pkg
// Brief    : Shared state encoding and address-field width helpers for the
//            direct-mapped write-through cache.
// Revision : 1.0
// ============================================================================
package cache_pkg;

  localparam int c_BYTE_OFF_W = 2;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FILL  = 2'd1,
    S_WRITE = 2'd2
  } cache_state_t;

  function automatic int calc_off_w(input int words);
    return $clog2(words);
  endfunction

  function automatic int calc_idx_w(input int lines);
    return $clog2(lines);
  endfunction

  function automatic int calc_tag_w(input int addr_w, input int lines, input int words);
    return addr_w - c_BYTE_OFF_W - calc_off_w(words) - calc_idx_w(lines);
  endfunction

endpackage : cache_pkg
`default_nettype wire

// File: rtl/cache_dm_line_ram.sv
`default_nettype none
// ============================================================================
// Module   : cache_dm_line_ram
// Brief    : LINES x WORDS data array, one word write port and one
//            combinational word read port, addressed {idx, off}.
// Revision : 1.0
// ============================================================================
module cache_dm_line_ram #(
  parameter int LINES  = 8,
  parameter int WORDS  = 8,
  parameter int DATA_W = 32,
  localparam int c_AW  = $clog2(LINES * WORDS)
) (
  input  logic              clk,
  input  logic              i_we,
  input  logic [c_AW-1:0]   i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic [c_AW-1:0]   i_raddr,
  output logic [DATA_W-1:0] o_rdata
);

  logic [DATA_W-1:0] r_mem [LINES*WORDS];

  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule : cache_dm_line_ram
`default_nettype wire

// File: rtl/cache_dm_wt.sv
`default_nettype none
// ============================================================================
// Module   : cache_dm_wt
// Brief    : Direct-mapped, write-through, no-write-allocate cache with a
//            ready-handshaked memory port and full-line refill.
//            Optional macro CACHE_DM_WT_STATS_EN adds stat_hits/stat_misses.
// Revision : 1.0
// ============================================================================
module cache_dm_wt
  import cache_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int LINES  = 8,
  parameter int WORDS  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] addr,
  input  logic              renable,
  input  logic              wenable,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              hit,
  output logic              stall,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_renable,
  output logic              mem_wenable,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
`ifdef CACHE_DM_WT_STATS_EN
  output logic [31:0]       stat_hits,
  output logic [31:0]       stat_misses,
`endif
  input  logic              mem_ready
);

  localparam int c_OFF_W = calc_off_w(WORDS);
  localparam int c_IDX_W = calc_idx_w(LINES);
  localparam int c_TAG_W = calc_tag_w(ADDR_W, LINES, WORDS);
  localparam int c_RAM_AW = c_IDX_W + c_OFF_W;
  localparam logic [c_OFF_W-1:0] c_CNT_LAST = c_OFF_W'(WORDS - 1);

  cache_state_t r_state;
  cache_state_t w_state_nxt;
  logic [c_OFF_W-1:0] r_cnt;
  logic [LINES-1:0]   r_valid;
  logic [c_TAG_W-1:0] r_tag [LINES];

  logic [c_TAG_W-1:0] w_tag;
  logic [c_IDX_W-1:0] w_idx;
  logic [c_OFF_W-1:0] w_off;
  logic [ADDR_W-c_BYTE_OFF_W-c_OFF_W-1:0] w_line_base;
  logic               w_line_hit;
  logic               w_fill_start;
  logic               w_fill_done;
  logic               w_ram_we;
  logic [c_RAM_AW-1:0] w_ram_waddr;
  logic [DATA_W-1:0]  w_ram_wdata;
  logic [DATA_W-1:0]  w_ram_rdata;

  assign w_tag       = addr[ADDR_W-1 -: c_TAG_W];
  assign w_idx       = addr[c_BYTE_OFF_W+c_OFF_W +: c_IDX_W];
  assign w_off       = addr[c_BYTE_OFF_W +: c_OFF_W];
  assign w_line_base = addr[ADDR_W-1 : c_BYTE_OFF_W+c_OFF_W];

  assign w_line_hit = r_valid[w_idx] && (r_tag[w_idx] == w_tag);
  assign hit        = w_line_hit && (r_state == S_IDLE);
  assign rdata      = hit ? w_ram_rdata : '0;

  assign stall = (renable && !hit)
              || (wenable && ((r_state != S_WRITE) || !mem_ready))
              || (r_state == S_FILL);

  cache_dm_line_ram #(
    .LINES  (LINES),
    .WORDS  (WORDS),
    .DATA_W (DATA_W)
  ) u_line_ram (
    .clk     (clk),
    .i_we    (w_ram_we),
    .i_waddr (w_ram_waddr),
    .i_wdata (w_ram_wdata),
    .i_raddr ({w_idx, w_off}),
    .o_rdata (w_ram_rdata)
  );

  always_comb begin
    w_state_nxt  = r_state;
    mem_addr     = '0;
    mem_renable  = 1'b0;
    mem_wenable  = 1'b0;
    mem_wdata    = '0;
    w_ram_we     = 1'b0;
    w_ram_waddr  = {w_idx, w_off};
    w_ram_wdata  = wdata;
    w_fill_start = 1'b0;
    w_fill_done  = 1'b0;
    case (r_state)
      S_IDLE: begin
        // A simultaneous read and write is handled as a write only.
        if (wenable) begin
          w_state_nxt = S_WRITE;
        end else if (renable && !hit) begin
          w_state_nxt  = S_FILL;
          w_fill_start = 1'b1;
        end
      end
      S_FILL: begin
        mem_renable = 1'b1;
        mem_addr    = {w_line_base, r_cnt, 2'b00};
        w_ram_waddr = {w_idx, r_cnt};
        w_ram_wdata = mem_rdata;
        if (mem_ready) begin
          w_ram_we = 1'b1;
          if (r_cnt == c_CNT_LAST) begin
            w_fill_done = 1'b1;
            w_state_nxt = S_IDLE;
          end
        end
      end
      S_WRITE: begin
        mem_wenable = 1'b1;
        mem_addr    = addr;
        mem_wdata   = wdata;
        if (mem_ready) begin
          w_ram_we    = w_line_hit;
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_valid <= '0;
    end else begin
      r_state <= w_state_nxt;
      // The line stays invalid for the whole refill so partial data never hits.
      if (w_fill_start) begin
        r_cnt          <= '0;
        r_valid[w_idx] <= 1'b0;
      end else if ((r_state == S_FILL) && mem_ready) begin
        r_cnt <= r_cnt + c_OFF_W'(1);
      end
      if (w_fill_done) begin
        r_valid[w_idx] <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && w_fill_done) begin
      r_tag[w_idx] <= w_tag;
    end
  end

`ifdef CACHE_DM_WT_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_hits   <= '0;
      stat_misses <= '0;
    end else begin
      if ((r_state == S_IDLE) && renable && !wenable && hit) begin
        stat_hits <= stat_hits + 32'd1;
      end
      if (w_fill_start) begin
        stat_misses <= stat_misses + 32'd1;
      end
    end
  end
`endif

endmodule : cache_dm_wt
`default_nettype wire

// File: tb/tb_cache_dm_wt.sv
`default_nettype none
// ============================================================================
// Module   : tb_cache_dm_wt
// Brief    : Self-checking bench for cache_dm_wt: directed scenarios followed
//            by random reads/writes against a line-residency reference model.
// Revision : 1.0
// ============================================================================
module tb_cache_dm_wt;

  localparam int ADDR_W     = 32;
  localparam int DATA_W     = 32;
  localparam int LINES      = 8;
  localparam int WORDS      = 8;
  localparam int LINE_BYTES = WORDS * 4;

  logic              clk = 1'b0;
  logic              rst;
  logic [ADDR_W-1:0] addr;
  logic              renable;
  logic              wenable;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] rdata;
  logic              hit;
  logic              stall;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_renable;
  logic              mem_wenable;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ready;
`ifdef CACHE_DM_WT_STATS_EN
  logic [31:0]       stat_hits;
  logic [31:0]       stat_misses;
`endif

  cache_dm_wt #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .LINES  (LINES),
    .WORDS  (WORDS)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .addr        (addr),
    .renable     (renable),
    .wenable     (wenable),
    .wdata       (wdata),
    .rdata       (rdata),
    .hit         (hit),
    .stall       (stall),
    .mem_addr    (mem_addr),
    .mem_renable (mem_renable),
    .mem_wenable (mem_wenable),
    .mem_wdata   (mem_wdata),
    .mem_rdata   (mem_rdata),
`ifdef CACHE_DM_WT_STATS_EN
    .stat_hits   (stat_hits),
    .stat_misses (stat_misses),
`endif
    .mem_ready   (mem_ready)
  );

  always #5 clk = ~clk;

  int n_asserts = 0;
  int n_fail    = 0;
  int lat       = 0;   // wait cycles the memory inserts before mem_ready
  int wait_cnt  = 0;
  int n_mem_wr  = 0;

  logic [31:0] mem_store [logic [31:0]];
  bit          res_valid [LINES];
  int unsigned res_tag   [LINES];

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    if (mem_store.exists(a)) return mem_store[a];
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
  endfunction

  function automatic int unsigned idx_of(input logic [31:0] a);
    return (a / LINE_BYTES) % LINES;
  endfunction

  function automatic int unsigned tag_of(input logic [31:0] a);
    return a / (LINE_BYTES * LINES);
  endfunction

  function automatic bit model_hit(input logic [31:0] a);
    return res_valid[idx_of(a)] && (res_tag[idx_of(a)] == tag_of(a));
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Memory answers combinationally once its wait budget for this strobe is spent.
  task automatic settle();
    #1;
    if ((mem_renable || mem_wenable) && (wait_cnt >= lat)) begin
      mem_ready = 1'b1;
      mem_rdata = mem_renable ? mem_rd(mem_addr) : 32'h0;
    end else begin
      mem_ready = 1'b0;
      mem_rdata = $urandom;
    end
    #1;
  endtask

  task automatic advance();
    if (mem_wenable && mem_ready) begin
      mem_store[mem_addr] = mem_wdata;
      n_mem_wr++;
    end
    if (mem_renable || mem_wenable) wait_cnt = mem_ready ? 0 : wait_cnt + 1;
    else wait_cnt = 0;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_read(input logic [31:0] a);
    bit          exp_hit;
    int          stall_cyc;
    int          n_str;
    int          guard;
    logic [31:0] base;
    exp_hit   = model_hit(a);
    base      = a - (a % LINE_BYTES);
    stall_cyc = 0;
    n_str     = 0;
    guard     = 0;
    addr = a; renable = 1'b1; wenable = 1'b0;
    settle();
    check("rd_hit_first", hit, exp_hit);
    if (exp_hit) begin
      check("rd_hit_stall", stall, 1'b0);
      check("rd_hit_no_mem", mem_renable, 1'b0);
      check("rd_hit_data", rdata, mem_rd(a));
    end else begin
      check("rd_miss_rdata_zero", rdata, 32'h0);
      while (stall && guard < 400) begin
        stall_cyc++;
        if (mem_renable) begin
          check("fill_addr", mem_addr, base + 32'(4 * n_str));
          if (mem_ready) n_str++;
        end
        advance();
        settle();
        guard++;
      end
      if (guard >= 400) check("rd_timeout", 32'd0, 32'd1);
      check("fill_strobes", n_str, WORDS);
      if (lat == 0) check("miss_stall_cycles", stall_cyc, WORDS + 1);
      check("rd_after_fill_hit", hit, 1'b1);
      check("rd_after_fill_data", rdata, mem_rd(a));
      res_valid[idx_of(a)] = 1'b1;
      res_tag[idx_of(a)]   = tag_of(a);
    end
    advance();
    renable = 1'b0;
  endtask

  task automatic do_write(input logic [31:0] a, input logic [31:0] d);
    int stall_cyc;
    int guard;
    int wr_before;
    stall_cyc = 0;
    guard     = 0;
    wr_before = n_mem_wr;
    addr = a; wdata = d; wenable = 1'b1; renable = 1'b0;
    settle();
    while (stall && guard < 100) begin
      stall_cyc++;
      if (mem_wenable) begin
        check("wr_addr_held", mem_addr, a);
        check("wr_data_held", mem_wdata, d);
      end
      advance();
      settle();
      guard++;
    end
    if (guard >= 100) check("wr_timeout", 32'd0, 32'd1);
    check("wr_final_strobe", mem_wenable, 1'b1);
    check("wr_final_ready", mem_ready, 1'b1);
    // One decode cycle in IDLE plus every WRITE cycle spent waiting on memory.
    check("wr_stall_cycles", stall_cyc, lat + 1);
    advance();
    wenable = 1'b0;
    check("wr_mem_count", n_mem_wr - wr_before, 1);
  endtask

  initial begin
    logic [31:0] ra;
    logic [31:0] rd;
    rst = 1'b1; addr = '0; renable = 1'b0; wenable = 1'b0; wdata = '0;
    mem_rdata = '0; mem_ready = 1'b0;
    for (int i = 0; i < LINES; i++) begin
      res_valid[i] = 1'b0;
      res_tag[i]   = 0;
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    addr = 32'h100;
    settle();
    check("rst_hit", hit, 1'b0);
    check("rst_rdata", rdata, 32'h0);
    check("rst_stall", stall, 1'b0);
    check("rst_mem_ren", mem_renable, 1'b0);
    check("rst_mem_wen", mem_wenable, 1'b0);
    check("rst_mem_addr", mem_addr, 32'h0);
    check("rst_mem_wdata", mem_wdata, 32'h0);

    lat = 0;
    do_read(32'h0000_0100);
    do_read(32'h0000_0114);

    lat = 3;
    do_write(32'h0000_0104, 32'hDEAD_BEEF);
    lat = 0;
    do_read(32'h0000_0104);
    check("wr_hit_readback", mem_rd(32'h104), 32'hDEAD_BEEF);

    do_write(32'h0000_2000, 32'h1234_5678);
    do_read(32'h0000_2000);

    do_read(32'h0000_0200);
    do_read(32'h0000_0100);

    // Reset while the refill is three words in.
    addr = 32'h300; renable = 1'b1;
    settle();
    advance();
    for (int i = 0; i < 3; i++) begin
      settle();
      advance();
    end
    settle();
    check("rst_fill_cnt3_addr", mem_addr, 32'h30C);
    rst = 1'b1;
    settle();
    advance();
    rst = 1'b0; renable = 1'b0;
    settle();
    check("midrst_mem_ren", mem_renable, 1'b0);
    check("midrst_mem_wen", mem_wenable, 1'b0);
    check("midrst_mem_addr", mem_addr, 32'h0);
    check("midrst_stall", stall, 1'b0);
    for (int i = 0; i < LINES; i++) res_valid[i] = 1'b0;
    do_read(32'h0000_0300);
    do_read(32'h0000_0100);

    for (int n = 0; n < 80; n++) begin
      lat = $urandom_range(0, 2);
      ra  = 32'($urandom_range(0, 2) * LINE_BYTES * LINES
              + $urandom_range(0, LINES - 1) * LINE_BYTES
              + $urandom_range(0, WORDS - 1) * 4);
      rd  = $urandom;
      if ($urandom_range(0, 2) == 2) do_write(ra, rd);
      else do_read(ra);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule : tb_cache_dm_wt
`default_nettype wire
